// File: rtl/pulse_peak_finder.sv
// Negative-going pulse peak finder with timestamped FIFO event output.
// Ports: clk/reset (sync, active-high); daq_enable, adc_in[13:0],
//   trig_level, rearm_level, holdoff[15:0], fifo_full in;
//   event_data[63:0]={peak,ts}, event_wr, timestamp[49:0],
//   event_count/drop_count[31:0], state[1:0] out.
module pulse_peak_finder (
  input  logic        clk,
  input  logic        reset,
  input  logic        daq_enable,
  input  logic [13:0] adc_in,
  input  logic [13:0] trig_level,
  input  logic [13:0] rearm_level,
  input  logic [15:0] holdoff,
  input  logic        fifo_full,
  output logic [63:0] event_data,
  output logic        event_wr,
  output logic [49:0] timestamp,
  output logic [31:0] event_count,
  output logic [31:0] drop_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACK   = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  state_e      state_q;
  logic [13:0] adc_q;
  logic [13:0] peak_q;
  logic [49:0] peak_ts_q;
  logic [49:0] ts_q;
  logic [15:0] hold_q;
  logic [63:0] evd_q;
  logic        evwr_q;
  logic [31:0] evcnt_q;
  logic [31:0] drop_q;

  logic [13:0] rearm_eff;
  logic        below_trig;
  logic        above_rearm;
  logic        new_min;
  logic [31:0] evcnt_d;
  logic [31:0] drop_d;
  logic [49:0] ts_d;

  // A rearm level below the trigger would re-arm inside the pulse,
  // so the effective end level is never lower than the trigger.
  always_comb begin
    rearm_eff = (rearm_level > trig_level)
              ? rearm_level : trig_level;
    below_trig  = adc_q < trig_level;
    above_rearm = adc_q > rearm_eff;
    new_min     = adc_q < peak_q;
    evcnt_d = (&evcnt_q) ? evcnt_q : evcnt_q + 32'd1;
    drop_d  = (&drop_q)  ? drop_q  : drop_q  + 32'd1;
    ts_d    = daq_enable ? ts_q + 50'd8 : ts_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      adc_q     <= '0;
      peak_q    <= '0;
      peak_ts_q <= '0;
      ts_q      <= '0;
      hold_q    <= '0;
      evd_q     <= '0;
      evwr_q    <= 1'b0;
      evcnt_q   <= '0;
      drop_q    <= '0;
    end else begin
      adc_q  <= adc_in;
      ts_q   <= ts_d;
      evwr_q <= 1'b0;
      // Losing the window abandons any pulse in progress.
      if (!daq_enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (below_trig) begin
              state_q   <= TRACK;
              peak_q    <= adc_q;
              peak_ts_q <= ts_q;
            end
          end
          TRACK: begin
            if (above_rearm) begin
              state_q <= HOLDOFF;
              hold_q  <= holdoff;
              evd_q   <= {peak_q, peak_ts_q};
              if (fifo_full) begin
                drop_q <= drop_d;
              end else begin
                evwr_q  <= 1'b1;
                evcnt_q <= evcnt_d;
              end
            end else if (new_min) begin
              // Strict compare keeps the earliest of equal minima.
              peak_q    <= adc_q;
              peak_ts_q <= ts_q;
            end
          end
          HOLDOFF: begin
            if (hold_q != 16'd0) begin
              hold_q <= hold_q - 16'd1;
            end else if (above_rearm) begin
              state_q <= ARMED;
            end
          end
        endcase
      end
    end
  end

  assign event_data  = evd_q;
  assign event_wr    = evwr_q;
  assign timestamp   = ts_q;
  assign event_count = evcnt_q;
  assign drop_count  = drop_q;
  assign state       = state_q;

endmodule
